// File: rtl/tm1638_disp_arbiter.sv
// Round-robin display-ownership scheduler for a shared TM1638 board.
// Grants one of four requesters with a minimum hold, operator lock and skip.
module tm1638_disp_arbiter #(
  parameter int C_FCK     = 48_000_000,
  parameter int C_HOLD_MS = 2000
) (
  input  logic        CK_i,
  input  logic        XARST_i,
  input  logic [3:0]  REQ_i,
  input  logic [31:0] BIN0_i,
  input  logic [31:0] BIN1_i,
  input  logic [31:0] BIN2_i,
  input  logic [31:0] BIN3_i,
  input  logic [7:0]  CFG_i,
  input  logic [7:0]  KEYS_i,
  output logic [31:0] BIN_DAT_o,
  output logic        ENCBIN_XDIRECT_o,
  output logic        BIN2BCD_ON_o,
  output logic [3:0]  GNT_o,
  output logic [1:0]  OWNER_o,
  output logic        LOCK_o
);

  localparam int C_TICK = C_FCK / 1000;
  localparam int PW = (C_TICK > 1) ? $clog2(C_TICK) : 1;
  localparam int HW = $clog2(C_HOLD_MS + 1);
  localparam logic [PW-1:0] C_PMAX = PW'(C_TICK - 1);
  localparam logic [HW-1:0] C_HLD = HW'(C_HOLD_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_OPEN
  } state_t;

  state_t        r_st;
  logic [PW-1:0] r_pre;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_kd;
  logic [1:0]    r_edge;
  logic [1:0]    r_own;
  logic [3:0]    r_gnt;
  logic          r_lock;
  logic [31:0]   r_dat;
  logic          r_enc;
  logic          r_bcd;

  logic          w_tick;
  logic          w_oth_ok;
  logic [1:0]    w_oth;
  logic [1:0]    w_any;
  logic [31:0]   w_bin;
  logic [1:0]    w_cfg;
  logic          w_unused;

  assign w_tick   = (r_pre == C_PMAX);
  assign w_any    = w_oth_ok ? w_oth : r_own;
  assign w_cfg    = CFG_i[{r_own, 1'b0} +: 2];
  assign w_unused = &{1'b0, KEYS_i[5:0]};

  // lowest offset from the owner wins; the owner itself is never a candidate
  always_comb begin
    logic [1:0] v_idx;
    w_oth_ok = 1'b0;
    w_oth    = r_own;
    v_idx    = r_own;
    for (int i = 3; i >= 1; i--) begin
      v_idx = r_own + 2'(i);
      if (REQ_i[v_idx]) begin
        w_oth_ok = 1'b1;
        w_oth    = v_idx;
      end
    end
  end

  always_comb begin
    w_bin = BIN0_i;
    unique case (r_own)
      2'd0: w_bin = BIN0_i;
      2'd1: w_bin = BIN1_i;
      2'd2: w_bin = BIN2_i;
      2'd3: w_bin = BIN3_i;
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_pre  <= '0;
      r_kd   <= '0;
      r_edge <= '0;
    end else begin
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      r_kd   <= KEYS_i[7:6];
      r_edge <= KEYS_i[7:6] & ~r_kd;
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_st   <= S_IDLE;
      r_hold <= '0;
      r_own  <= 2'd3;
      r_gnt  <= '0;
      r_lock <= 1'b0;
      r_dat  <= '0;
      r_enc  <= 1'b1;
      r_bcd  <= 1'b1;
    end else begin
      if (r_edge[1]) r_lock <= ~r_lock;
      unique case (r_st)
        S_IDLE: begin
          if (|REQ_i) begin
            r_own  <= w_any;
            r_gnt  <= 4'b0001 << w_any;
            r_hold <= C_HLD;
            r_st   <= S_HOLD;
          end
        end
        S_HOLD, S_OPEN: begin
          if (!REQ_i[r_own]) begin
            if (w_oth_ok) begin
              r_own  <= w_oth;
              r_gnt  <= 4'b0001 << w_oth;
              r_hold <= C_HLD;
              r_st   <= S_HOLD;
            end else begin
              r_gnt <= '0;
              r_st  <= S_IDLE;
            end
          end else if (w_oth_ok && !r_lock &&
                       (r_edge[0] || r_st == S_OPEN)) begin
            r_own  <= w_oth;
            r_gnt  <= 4'b0001 << w_oth;
            r_hold <= C_HLD;
            r_st   <= S_HOLD;
          end else if (r_st == S_HOLD && w_tick) begin
            r_hold <= r_hold - 1'b1;
            if (r_hold == HW'(1)) r_st <= S_OPEN;
          end
        end
      endcase
      if (r_st == S_IDLE) begin
        r_dat <= '0;
        r_enc <= 1'b1;
        r_bcd <= 1'b1;
      end else begin
        r_dat <= w_bin;
        r_enc <= w_cfg[1];
        r_bcd <= w_cfg[0];
      end
    end
  end

  assign BIN_DAT_o        = r_dat;
  assign ENCBIN_XDIRECT_o = r_enc;
  assign BIN2BCD_ON_o     = r_bcd;
  assign GNT_o            = r_gnt;
  assign OWNER_o          = r_own;
  assign LOCK_o           = r_lock;

endmodule

// File: tb/tb_tm1638_disp_arbiter.sv
// Directed bench for tm1638_disp_arbiter: mux table plus
// hold, rotation, drop, lock and skip sequences.
module tb_tm1638_disp_arbiter;

  logic        CK_i = 1'b0;
  logic        XARST_i;
  logic [3:0]  REQ_i;
  logic [31:0] BIN0_i, BIN1_i, BIN2_i, BIN3_i;
  logic [7:0]  CFG_i;
  logic [7:0]  KEYS_i;
  logic [31:0] BIN_DAT_o;
  logic        ENCBIN_XDIRECT_o;
  logic        BIN2BCD_ON_o;
  logic [3:0]  GNT_o;
  logic [1:0]  OWNER_o;
  logic        LOCK_o;

  int total = 0;
  int bad = 0;

  tm1638_disp_arbiter #(
    .C_FCK(4000),
    .C_HOLD_MS(3)
  ) dut (
    .CK_i(CK_i),
    .XARST_i(XARST_i),
    .REQ_i(REQ_i),
    .BIN0_i(BIN0_i),
    .BIN1_i(BIN1_i),
    .BIN2_i(BIN2_i),
    .BIN3_i(BIN3_i),
    .CFG_i(CFG_i),
    .KEYS_i(KEYS_i),
    .BIN_DAT_o(BIN_DAT_o),
    .ENCBIN_XDIRECT_o(ENCBIN_XDIRECT_o),
    .BIN2BCD_ON_o(BIN2BCD_ON_o),
    .GNT_o(GNT_o),
    .OWNER_o(OWNER_o),
    .LOCK_o(LOCK_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cfg;
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic [31:0] dat;
    logic        enc;
    logic        bcd;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge CK_i);
    @(negedge CK_i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int n;
    tbl[0] = '{4'b0100, 8'h10, 4'b0100, 2'd2, 32'h1234_5678, 1'b0, 1'b1};
    tbl[1] = '{4'b0001, 8'h02, 4'b0001, 2'd0, 32'h0000_00A0, 1'b1, 1'b0};
    tbl[2] = '{4'b1000, 8'h80, 4'b1000, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[3] = '{4'b0010, 8'h0C, 4'b0010, 2'd1, 32'h1111_1111, 1'b1, 1'b1};
    tbl[4] = '{4'b0110, 8'h20, 4'b0100, 2'd2, 32'h1234_5678, 1'b1, 1'b0};
    tbl[5] = '{4'b0011, 8'h01, 4'b0001, 2'd0, 32'h0000_00A0, 1'b0, 1'b1};

    XARST_i = 1'b0;
    REQ_i   = 4'hF;
    BIN0_i  = 32'h0000_00A0;
    BIN1_i  = 32'h1111_1111;
    BIN2_i  = 32'h1234_5678;
    BIN3_i  = 32'hDEAD_BEEF;
    CFG_i   = 8'h00;
    KEYS_i  = 8'h00;
    step();
    step();
    chk("rst_gnt", 32'(GNT_o), 32'h0);
    chk("rst_own", 32'(OWNER_o), 32'd3);
    chk("rst_dat", BIN_DAT_o, 32'h0);
    chk("rst_fmt", 32'({ENCBIN_XDIRECT_o, BIN2BCD_ON_o}), 32'b11);
    chk("rst_lock", 32'(LOCK_o), 32'h0);
    XARST_i = 1'b1;
    step();
    chk("rel_gnt", 32'(GNT_o), 32'b0001);
    chk("rel_own", 32'(OWNER_o), 32'd0);
    REQ_i = 4'h0;
    step();

    for (int i = 0; i < 6; i++) begin
      step();
      chk("tbl_idle_gnt", 32'(GNT_o), 32'h0);
      chk("tbl_idle_dat", BIN_DAT_o, 32'h0);
      chk("tbl_idle_fmt", 32'({ENCBIN_XDIRECT_o, BIN2BCD_ON_o}), 32'b11);
      REQ_i = tbl[i].req;
      CFG_i = tbl[i].cfg;
      step();
      chk("tbl_gnt", 32'(GNT_o), 32'(tbl[i].gnt));
      chk("tbl_own", 32'(OWNER_o), 32'(tbl[i].own));
      step();
      chk("tbl_dat", BIN_DAT_o, tbl[i].dat);
      chk("tbl_enc", 32'(ENCBIN_XDIRECT_o), 32'(tbl[i].enc));
      chk("tbl_bcd", 32'(BIN2BCD_ON_o), 32'(tbl[i].bcd));
      REQ_i = 4'h0;
      step();
    end

    REQ_i = 4'b0011;
    step();
    chk("pre_rst_gnt", 32'(GNT_o), 32'b0010);
    XARST_i = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(GNT_o), 32'h0);
    chk("mid_rst_own", 32'(OWNER_o), 32'd3);
    chk("mid_rst_dat", BIN_DAT_o, 32'h0);
    @(negedge CK_i);
    XARST_i = 1'b1;
    step();
    chk("rot_start", 32'(GNT_o), 32'b0001);

    ok = 1'b1;
    repeat (8) begin
      step();
      if (GNT_o !== 4'b0001) ok = 1'b0;
    end
    chk("hold0", 32'(ok), 32'd1);
    n = 0;
    while (GNT_o === 4'b0001 && n < 20) begin
      step();
      n++;
    end
    chk("rot_to1", 32'(GNT_o), 32'b0010);
    ok = 1'b1;
    repeat (8) begin
      step();
      if (GNT_o !== 4'b0010) ok = 1'b0;
    end
    chk("hold1", 32'(ok), 32'd1);
    n = 0;
    while (GNT_o === 4'b0010 && n < 20) begin
      step();
      n++;
    end
    chk("rot_to0", 32'(GNT_o), 32'b0001);

    REQ_i = 4'b0010;
    step();
    chk("drop0_gnt", 32'(GNT_o), 32'b0010);
    REQ_i = 4'b1001;
    step();
    chk("drop1_gnt", 32'(GNT_o), 32'b1000);
    chk("drop1_own", 32'(OWNER_o), 32'd3);
    REQ_i = 4'b0000;
    step();
    chk("dropall_gnt", 32'(GNT_o), 32'h0);
    chk("dropall_own", 32'(OWNER_o), 32'd3);
    step();
    chk("dropall_dat", BIN_DAT_o, 32'h0);

    REQ_i = 4'b0011;
    step();
    chk("lock_own0", 32'(GNT_o), 32'b0001);
    KEYS_i = 8'h80;
    step();
    chk("lock_1cyc", 32'(LOCK_o), 32'd0);
    step();
    chk("lock_2cyc", 32'(LOCK_o), 32'd1);
    ok = 1'b1;
    repeat (30) begin
      step();
      if (GNT_o !== 4'b0001 || LOCK_o !== 1'b1) ok = 1'b0;
    end
    chk("lock_held", 32'(ok), 32'd1);
    KEYS_i = 8'h00;
    step();
    KEYS_i = 8'h80;
    step();
    step();
    chk("unlock", 32'(LOCK_o), 32'd0);
    step();
    chk("unlock_take", 32'(GNT_o), 32'b0010);
    KEYS_i = 8'h00;

    REQ_i = 4'b0001;
    step();
    chk("skip_own0", 32'(GNT_o), 32'b0001);
    REQ_i  = 4'b0101;
    KEYS_i = 8'h40;
    step();
    chk("skip_early", 32'(GNT_o), 32'b0001);
    step();
    chk("skip_gnt", 32'(GNT_o), 32'b0100);
    ok = 1'b1;
    repeat (6) begin
      step();
      if (GNT_o !== 4'b0100) ok = 1'b0;
    end
    chk("skip_reload", 32'(ok), 32'd1);
    KEYS_i = 8'h00;
    step();
    KEYS_i = 8'hC0;
    step();
    step();
    chk("both_gnt", 32'(GNT_o), 32'b0001);
    chk("both_lock", 32'(LOCK_o), 32'd1);
    KEYS_i = 8'h00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
